// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, round-key type, Rcon table and the
// reverse key-schedule FSM state type.
package aes_pkg;

    localparam int unsigned AES_NR = 10;

    typedef logic [127:0] round_key_t;

    typedef enum logic {StIdle, StServe} kx_state_t;

    // Round constant for rounds 1..10; zero outside that range.
    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/inv_key_expansion_if.sv
// Start/key-stream handshake between the reverse key schedule and its consumer.
interface inv_key_expansion_if;
    import aes_pkg::*;

    logic       iStart;
    round_key_t iLastKey;
    logic       iReady;
    round_key_t oRoundKey;
    logic [3:0] oRound;
    logic       oValid;
    logic       oBusy;
    logic       oDone;

    modport slave (
        input  iStart, iLastKey, iReady,
        output oRoundKey, oRound, oValid, oBusy, oDone
    );

    modport master (
        output iStart, iLastKey, iReady,
        input  oRoundKey, oRound, oValid, oBusy, oDone
    );

endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box, combinational, one byte.
module aes_sbox (
    input  logic [7:0] plain,
    output logic [7:0] subst
);

    // Entry 0 sits in the top byte, entry 255 in the bottom byte.
    localparam logic [2047:0] SboxRom = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // 255 - plain == ~plain, so the byte offset is just the inverted index.
    logic [10:0] bit_idx;
    assign bit_idx = {~plain, 3'b000};
    assign subst   = SboxRom[bit_idx +: 8];

endmodule

// File: rtl/inv_key_expansion.sv
// AES-128 reverse key schedule: serves round keys 10 down to 0 from the final
// round key, holding a single round key and deriving the previous one per cycle.
module inv_key_expansion
    import aes_pkg::*;
#(
    parameter int unsigned ROUNDS = AES_NR
) (
    input logic                iClk,
    input logic                iRst,
    inv_key_expansion_if.slave kx
);

    kx_state_t  state_q, state_d;
    round_key_t key_q, key_d;
    logic [3:0] round_q, round_d;
    logic       done_q, done_d;

    logic [31:0] w0, w1, w2, w3, p3;
    logic [31:0] rot_word, sub_word;
    round_key_t  prev_key;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    // p3 of the previous key is w3 of that key, which feeds its own RotWord/SubWord.
    assign p3       = w3 ^ w2;
    assign rot_word = {p3[23:0], p3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .plain (rot_word[8*i +: 8]),
            .subst (sub_word[8*i +: 8])
        );
    end

    assign prev_key = {w0 ^ sub_word ^ {rcon(round_q), 24'h0}, w1 ^ w0, w2 ^ w1, p3};

    // Next-state: capture on start, step back one round per accept, finish after round 0.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (kx.iStart) begin
                    state_d = StServe;
                    key_d   = kx.iLastKey;
                    round_d = 4'(ROUNDS);
                end
            end
            StServe: begin
                if (kx.iReady) begin
                    if (round_q == 4'd0) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        key_d   = prev_key;
                        round_d = round_q - 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= StIdle;
            key_q   <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    assign kx.oRoundKey = key_q;
    assign kx.oRound    = round_q;
    assign kx.oValid    = (state_q == StServe);
    assign kx.oBusy     = (state_q == StServe);
    assign kx.oDone     = done_q;

endmodule
